// File: rtl/pc_fetch_unit.sv
// Instruction fetch sequencer: owns PC/MAR/IR and runs the MOC read handshake,
// with bounded wait states, branch/jump redirect and a sticky fault state.
module pc_fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                INSTR_BYTES  = 4,
    parameter int                TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              update_pc,
    input  logic [1:0]        pc_sel,
    input  logic [15:0]       br_offset,
    input  logic [25:0]       j_index,
    input  logic              moc,
    input  logic [31:0]       mem_data,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mar,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code,
    input  logic              fault_clr
);
    localparam int SHIFT = $clog2(INSTR_BYTES);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, FAULT} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] br_tgt, jmp_tgt, target;
    logic              redirect, misaligned, timed_out;

    always_comb begin
        br_tgt     = pc + ({{(ADDR_W-16){br_offset[15]}}, br_offset} << SHIFT);
        jmp_tgt    = {pc[ADDR_W-1:28], j_index, 2'b00};
        redirect   = update_pc && (pc_sel == 2'b01 || pc_sel == 2'b10);
        target     = (pc_sel == 2'b01) ? br_tgt : jmp_tgt;
        misaligned = redirect && ((target & ADDR_W'(INSTR_BYTES - 1)) != '0);
        // moc on the final wait edge still counts as a completion
        timed_out  = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !moc;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (misaligned) state_nxt = FAULT;
                   else if (fetch_req) state_nxt = ADDR;
            ADDR:  state_nxt = WAIT;
            WAIT:  if (moc) state_nxt = IDLE;
                   else if (timed_out) state_nxt = FAULT;
            FAULT: if (fault_clr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_VECTOR;
            fetch_pc   <= RESET_VECTOR;
            mar        <= '0;
            ir         <= '0;
            ir_valid   <= 1'b0;
            mem_enable <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            wait_cnt   <= '0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (misaligned) begin
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                    end else if (redirect) begin
                        pc <= target;
                    end
                end
                ADDR: begin
                    mar        <= pc;
                    fetch_pc   <= pc;
                    mem_enable <= 1'b1;
                    wait_cnt   <= '0;
                end
                WAIT: begin
                    if (moc) begin
                        ir         <= mem_data;
                        ir_valid   <= 1'b1;
                        mem_enable <= 1'b0;
                        pc         <= pc + ADDR_W'(INSTR_BYTES);
                    end else if (timed_out) begin
                        mem_enable <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= 2'b01;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign mem_rw = 1'b0;
endmodule
